sl_cdc_rx_buffer: RTL and testbench
===================================

Name: sl_cdc_rx_buffer

Overview:
- Sits directly downstream of the sector-logic CDC synchroniser, in the read-clock domain.
- Consumes the synchroniser's output word, whose MSB is a valid tag and whose payload is all-zero when not valid.
- Buffers valid words in a small first-word-fall-through FIFO and presents them to the next stage with a valid/ready handshake.
- Counts and flags dropped words so that slow-consumer overruns are visible to monitoring.

Parameters:
- WIDTH, 193, width of the incoming tagged word; bit WIDTH-1 is valid, bits WIDTH-2:0 are payload.
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- CNT_WIDTH, 16, width of the overflow counter.

Ports:
- clk  input  1  read-domain clock; single clock for the whole block.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  tagged word from the CDC stage; a word is present when data_in[WIDTH-1]=1.
- data_out  output  WIDTH-1  head-of-FIFO payload; all-zero when data_out_valid=0.
- data_out_valid  output  1  head entry is available.
- data_out_ready  input  1  downstream accepts the head entry this cycle.
- occupancy  output  $clog2(DEPTH+1)  number of stored entries, 0..DEPTH.
- high_water  output  $clog2(DEPTH+1)  maximum occupancy since reset or the last clear_stats.
- overflow_flag  output  1  sticky; set on the first dropped word.
- overflow_cnt  output  CNT_WIDTH  dropped-word count; saturates at all-ones.
- clear_stats  input  1  synchronous pulse; clears overflow_flag, overflow_cnt and high_water.

Behaviour:
- Reset: clk is single; rst is asynchronous and active-high.
  - While rst=1, all outputs are 0: data_out, data_out_valid, occupancy, high_water, overflow_flag, overflow_cnt.
  - Reset empties the FIFO: read and write pointers go to 0.
  - Reset asserted mid-operation discards all stored entries immediately. No partial word is ever presented.
- Push and pop conditions:
  - push_req = data_in[WIDTH-1].
  - pop = data_out_valid & data_out_ready.
  - The payload is stored without the valid bit.
- Pointers and status:
  - Read and write pointers are $clog2(DEPTH)+1 bits; the extra bit distinguishes full from empty.
  - full = (occupancy == DEPTH).
  - empty = (occupancy == 0).
- Write acceptance: a write occurs when push_req & (~full | pop).
  - Full with a simultaneous pop: the push is accepted and occupancy stays at DEPTH.
- Drop:
  - Condition: push_req & full & ~pop. The word is discarded and FIFO contents are unchanged.
  - On a drop, overflow_cnt increments (saturating) and overflow_flag is set.
- Latency and output path:
  - A word sampled at clk edge N appears on data_out with data_out_valid=1 in the cycle after edge N.
  - There is no combinational path from data_in to the outputs.
  - data_out_valid = ~empty, driven from registered state only. data_out is gated to zero when empty.
- Handshake:
  - data_out and data_out_valid are held stable while data_out_valid=1 and data_out_ready=0.
  - data_out_ready with empty=1 has no effect.
- Occupancy update per edge:
  - +1 on write without pop.
  - -1 on pop without write.
  - Unchanged on both or neither.
- high_water: updated to next occupancy when it exceeds the current high_water.
- clear_stats:
  - high_water is set to the post-edge occupancy, not 0.
  - If a drop occurs in the same cycle as clear_stats, clear wins: counter = 0, flag = 0.
- Wrap-around: pointers wrap modulo 2*DEPTH. Ordering is strictly FIFO across wrap.
- No state machine beyond the pointers. All status registers are clocked by clk and reset by rst.

Test Plan:
1. Reset then single word: release rst and drive data_in={1'b1, 192'hA5} for 1 cycle with ready=0. The next cycle shows data_out=192'hA5, valid=1, occupancy=1. Then assert ready for 1 cycle, giving valid=0, data_out=0, occupancy=0.
2. Invalid words ignored: drive data_in={1'b0, 192'hFFFF} for 5 cycles. Valid stays 0 and occupancy stays 0.
3. Fill and overflow: with ready=0, push payloads 1..10 back-to-back (DEPTH=8). Occupancy reaches 8, overflow_cnt=2, overflow_flag=1, high_water=8. Draining with ready=1 yields 1..8 in order.
4. Full with simultaneous push/pop: with the FIFO full of 1..8, push 9 with ready=1 in the same cycle. Payload 1 is popped, 9 is accepted, occupancy stays 8 and overflow_cnt is unchanged. The drain order is 2..9.
5. Wrap and throughput: push 100 consecutive words (1..100) with ready=1 continuously. Output equals input delayed by 1 cycle, there are no drops, and high_water=1.
6. Reset mid-operation and clear:
   - Assert rst asynchronously with 5 entries and overflow_cnt=3. All outputs go to 0 immediately.
   - Separately, pulse clear_stats during a drop cycle. overflow_cnt=0, flag=0, and high_water equals the current occupancy.

Source files
------------

// File: rtl/sl_cdc_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sl_cdc_rx_buffer
// Purpose  : Read-domain receive buffer behind the sector-logic CDC
//            synchroniser. Words whose tag bit (MSB) is set are queued in a
//            first-word-fall-through FIFO and offered downstream through a
//            valid/ready handshake. Words that arrive while the FIFO is full
//            and nothing is being popped are dropped, and the drop is counted
//            and flagged.
// Ports    : clk, rst            - single clock, async active-high reset
//            data_in             - tagged word {valid, payload}
//            data_out[_valid]    - head payload (zero when empty) / head valid
//            data_out_ready      - downstream accepts head this cycle
//            occupancy           - stored entries, 0..DEPTH
//            high_water          - peak occupancy since reset / clear_stats
//            overflow_flag/_cnt  - sticky drop flag / saturating drop count
//            clear_stats         - clears flag, count, and rebases high_water
// Revision : 1.0 - initial release
// ============================================================================
module sl_cdc_rx_buffer #(
  parameter int WIDTH     = 193,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-2:0]           data_out,
  output logic                       data_out_valid,
  input  logic                       data_out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] high_water,
  output logic                       overflow_flag,
  output logic [CNT_WIDTH-1:0]       overflow_cnt,
  input  logic                       clear_stats
);

  localparam int PW = WIDTH - 1;           // payload width
  localparam int AW = $clog2(DEPTH);       // storage index width
  localparam int OW = $clog2(DEPTH + 1);   // occupancy width (AW+1 for pow2)

  // Storage is deliberately not reset: the output is gated by the valid
  // flag, so stale contents are never visible.
  logic [PW-1:0]        mem_q [DEPTH];

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]        hw_q, hw_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  logic [OW-1:0]        occ;
  logic [OW-1:0]        occ_d;
  logic                 full, empty;
  logic                 push_req, pop, wr_en, drop;

  assign occ      = OW'(wr_ptr_q - rd_ptr_q);
  assign full     = (occ == OW'(DEPTH));
  assign empty    = (occ == '0);
  assign push_req = data_in[WIDTH-1];
  assign pop      = ~empty & data_out_ready;
  // A pop frees the head slot in the same edge, so a full FIFO can still
  // take the incoming word when the consumer is draining.
  assign wr_en    = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    hw_d       = hw_q;
    ovf_flag_d = ovf_flag_q;
    ovf_cnt_d  = ovf_cnt_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    occ_d = OW'(wr_ptr_d - rd_ptr_d);

    // clear_stats rebases the peak to the post-edge fill level and takes
    // priority over a simultaneous drop.
    if (clear_stats) begin
      hw_d       = occ_d;
      ovf_flag_d = 1'b0;
      ovf_cnt_d  = '0;
    end else begin
      if (occ_d > hw_q) hw_d = occ_d;
      if (drop) begin
        ovf_flag_d = 1'b1;
        if (~&ovf_cnt_q) ovf_cnt_d = ovf_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hw_q       <= '0;
      ovf_flag_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hw_q       <= hw_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_in[PW-1:0];
  end

  assign data_out_valid = ~empty;
  assign data_out       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign occupancy      = occ;
  assign high_water     = hw_q;
  assign overflow_flag  = ovf_flag_q;
  assign overflow_cnt   = ovf_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sl_cdc_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sl_cdc_rx_buffer
// Purpose  : Self-checking bench for sl_cdc_rx_buffer. Stimulus queues the
//            payloads it expects to be accepted; an independent monitor
//            compares every handshaked output word against that queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sl_cdc_rx_buffer;

  localparam int WIDTH = 193;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int OW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-2:0] data_out;
  logic             data_out_valid;
  logic             data_out_ready = 1'b0;
  logic [OW-1:0]    occupancy;
  logic [OW-1:0]    high_water;
  logic             overflow_flag;
  logic [CW-1:0]    overflow_cnt;
  logic             clear_stats = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  logic [WIDTH-2:0] sb[$];

  sl_cdc_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .occupancy      (occupancy),
    .high_water     (high_water),
    .overflow_flag  (overflow_flag),
    .overflow_cnt   (overflow_cnt),
    .clear_stats    (clear_stats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs change and status is sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-2:0] p, input bit accepted);
    data_in = {1'b1, p};
    if (accepted) sb.push_back(p);
    tick();
    data_in = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"},  data_out,       0);
    chk({tag, "_valid"}, data_out_valid, 0);
    chk({tag, "_occ"},   occupancy,      0);
    chk({tag, "_hw"},    high_water,     0);
    chk({tag, "_flag"},  overflow_flag,  0);
    chk({tag, "_cnt"},   overflow_cnt,   0);
  endtask

  // Monitor: a word is consumed at the next edge whenever valid & ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_out_valid && data_out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_word", data_out, 0);
        else                chk("sb_word", data_out, sb.pop_front());
      end else if (!data_out_valid) begin
        chk("idle_dout_zero", data_out, 0);
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk_all_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: single word, held while not ready, then popped
    push(192'hA5, 1'b1);
    chk("t1_valid", data_out_valid, 1);
    chk("t1_dout",  data_out, 192'hA5);
    chk("t1_occ",   occupancy, 1);
    tick();
    chk("t1_hold_dout", data_out, 192'hA5);
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    chk("t1_empty_valid", data_out_valid, 0);
    chk("t1_empty_dout",  data_out, 0);
    chk("t1_empty_occ",   occupancy, 0);

    // 2: untagged words are ignored
    data_in = {1'b0, 192'hFFFF};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_occ", occupancy, 0);
    end
    data_in = '0;

    // 3: fill past DEPTH with no consumer
    for (int i = 1; i <= 10; i++) push(192'(i), i <= DEPTH);
    chk("t3_occ",  occupancy, DEPTH);
    chk("t3_cnt",  overflow_cnt, 2);
    chk("t3_flag", overflow_flag, 1);
    chk("t3_hw",   high_water, DEPTH);
    chk("t3_head", data_out, 1);

    // 4: push while full and popping: accepted, no drop; drain gives 2..9
    data_out_ready = 1'b1;
    push(192'd9, 1'b1);
    chk("t4_occ", occupancy, DEPTH);
    chk("t4_cnt", overflow_cnt, 2);
    for (int i = 0; i < DEPTH; i++) tick();
    data_out_ready = 1'b0;
    chk("t4_drained_occ", occupancy, 0);
    chk("t4_sb_empty", sb.size(), 0);

    // 5: clear stats when empty, then 100 words streamed through
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("t5_clr_hw",   high_water, 0);
    chk("t5_clr_cnt",  overflow_cnt, 0);
    chk("t5_clr_flag", overflow_flag, 0);
    data_out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      push(192'(i), 1'b1);
      chk("t5_occ", occupancy, 1);
    end
    tick();
    data_out_ready = 1'b0;
    chk("t5_hw",  high_water, 1);
    chk("t5_cnt", overflow_cnt, 0);
    chk("t5_occ_end", occupancy, 0);

    // 6a: 5 entries stored, 3 drops, then asynchronous reset
    for (int i = 1; i <= 11; i++) push(192'(200 + i), i <= DEPTH);
    data_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    data_out_ready = 1'b0;
    chk("t6_occ", occupancy, 5);
    chk("t6_cnt", overflow_cnt, 3);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_rst_occ", occupancy, 0);

    // 6b: clear_stats coinciding with a drop wins
    for (int i = 1; i <= DEPTH; i++) push(192'(300 + i), 1'b1);
    push(192'd399, 1'b0);
    chk("t6_drop_cnt", overflow_cnt, 1);
    clear_stats = 1'b1;
    push(192'd398, 1'b0);
    clear_stats = 1'b0;
    chk("t6_clr_cnt",  overflow_cnt, 0);
    chk("t6_clr_flag", overflow_flag, 0);
    chk("t6_clr_hw",   high_water, DEPTH);
    chk("t6_clr_occ",  occupancy, DEPTH);
    data_out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    data_out_ready = 1'b0;
    tick();
    chk("t6_final_occ", occupancy, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
